// File: rtl/obstacle_spawn_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// obstacle_pkg : shared constants and state encoding for obstacle spawning
// Rev 1.0
// ============================================================================
package obstacle_pkg;

    localparam logic [1:0]  GS_PLAYING       = 2'b10;
    localparam int          SCREEN_W_DEFAULT = 640;
    localparam logic [15:0] LFSR_MASK        = 16'hB400;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_CLEAR = 2'd1,
        GAP        = 2'd2,
        RELEASE    = 2'd3
    } spawn_state_t;

endpackage
`default_nettype wire

// File: rtl/obstacle_spawn_scheduler_lfsr.sv
`default_nettype none
// ============================================================================
// lfsr_galois16 : free-running 16-bit Galois LFSR, reloads seed on reset
// Rev 1.0
// ============================================================================
module lfsr_galois16
    import obstacle_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= seed;
        end else begin
            q <= q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/obstacle_spawn_scheduler.sv
`default_nettype none
// ============================================================================
// obstacle_spawn_scheduler : times obstacle releases and picks their sprite.
// Optional OBS_SPAWN_DIFFICULTY_EN shrinks the minimum gap every 8 spawns.
// Rev 1.0
// ============================================================================
module obstacle_spawn_scheduler
    import obstacle_pkg::*;
#(
    parameter int          SCREEN_W  = SCREEN_W_DEFAULT,
    parameter int          MIN_GAP   = 30,
    parameter int          GAP_BITS  = 6,
    parameter int          NUM_SEL   = 6,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        move_tick,
    input  logic [1:0]  game_state,
    input  logic [10:0] obs_x,
    input  logic [7:0]  obs_w,
    // "release" is a reserved word, hence the _req suffix
    output logic        release_req,
    output logic [3:0]  obstacle_sel,
    output logic [7:0]  spawn_count
);

    localparam int                 GW         = $clog2(MIN_GAP + 2**GAP_BITS);
    localparam logic [GW-1:0]      MIN_GAP_W  = GW'(MIN_GAP);
    localparam logic [GW-1:0]      SHRINK_MAX = GW'(MIN_GAP / 2);
    localparam logic signed [11:0] SCREEN_S   = 12'(SCREEN_W);

    logic [15:0]        lfsr;
    logic               unused_lfsr_bits;
    logic signed [11:0] x_s;
    logic signed [11:0] right_edge;
    logic               in_range;
    logic               ack;
    logic [3:0]         sel_map;
    logic [GW-1:0]      shrink;
    logic [GW-1:0]      gap_load;

    spawn_state_t       state,   state_nx;
    logic [GW-1:0]      gap_cnt, gap_nx;
    logic               rel_nx;
    logic [3:0]         sel_nx;
    logic [7:0]         cnt_nx;

    lfsr_galois16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (LFSR_SEED),
        .q     (lfsr)
    );

    assign unused_lfsr_bits = ^{lfsr[15], lfsr[11:GAP_BITS]};

    // Lane occupancy in 12-bit signed space so off-left positions compare correctly
    assign x_s        = {obs_x[10], obs_x};
    assign right_edge = x_s + $signed({4'b0000, obs_w});
    assign in_range   = (right_edge > 12'sd0) && (x_s <= SCREEN_S);
    assign ack        = in_range && (x_s < SCREEN_S);

    assign sel_map  = ({1'b0, lfsr[14:12]} >= 4'(NUM_SEL)) ?
                      ({1'b0, lfsr[14:12]} - 4'(NUM_SEL)) : {1'b0, lfsr[14:12]};
    assign gap_load = MIN_GAP_W - shrink + GW'(lfsr[GAP_BITS-1:0]);

`ifdef OBS_SPAWN_DIFFICULTY_EN
    logic       ack_fire;
    logic [2:0] ack_cnt;

    assign ack_fire = (state == RELEASE) && (game_state == GS_PLAYING) && ack;

    // Survives pauses on purpose: difficulty only resets with the game
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_cnt <= 3'd0;
            shrink  <= '0;
        end else if (ack_fire) begin
            ack_cnt <= ack_cnt + 3'd1;
            if (ack_cnt == 3'd7) begin
                shrink <= ((shrink + GW'(2)) > SHRINK_MAX) ? SHRINK_MAX : (shrink + GW'(2));
            end
        end
    end
`else
    assign shrink = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            release_req  <= 1'b0;
            obstacle_sel <= 4'd0;
            spawn_count  <= 8'd0;
        end else begin
            state        <= state_nx;
            gap_cnt      <= gap_nx;
            release_req  <= rel_nx;
            obstacle_sel <= sel_nx;
            spawn_count  <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        gap_nx   = gap_cnt;
        rel_nx   = release_req;
        sel_nx   = obstacle_sel;
        cnt_nx   = spawn_count;
        if (game_state != GS_PLAYING) begin
            state_nx = IDLE;
            rel_nx   = 1'b0;
            gap_nx   = '0;
        end else begin
            case (state)
                IDLE: state_nx = WAIT_CLEAR;
                WAIT_CLEAR: begin
                    if (!in_range) begin
                        state_nx = GAP;
                        gap_nx   = gap_load;
                    end
                end
                GAP: begin
                    if (move_tick) begin
                        if (gap_cnt == '0) begin
                            rel_nx   = 1'b1;
                            sel_nx   = sel_map;
                            state_nx = RELEASE;
                        end else begin
                            gap_nx = gap_cnt - GW'(1);
                        end
                    end
                end
                RELEASE: begin
                    if (ack) begin
                        rel_nx   = 1'b0;
                        cnt_nx   = spawn_count + 8'd1;
                        state_nx = WAIT_CLEAR;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
